// File: rtl/pipe_stage_seq_if.sv
// Handshake, configuration and operand bundle for pipe_stage_seq.
// The master drives run requests and operands; the slave reports progress.
interface pipe_stage_seq_if #(
   parameter int CHANNELS   = 3,
   parameter int NUM_STAGES = 8,
   parameter int STEP_W     = 16,
   parameter int WIDTH      = 16
);
   localparam int SW = $clog2(NUM_STAGES + 1);

   logic                           start_i;
   logic                           valid_i;
   logic [NUM_STAGES*STEP_W-1:0]   boundary_i;
   logic [NUM_STAGES*2-1:0]        mode_i;
   logic [NUM_STAGES-1:0]          clear_mask_i;
   logic [CHANNELS*WIDTH-1:0]      opa_i;
   logic [CHANNELS*WIDTH-1:0]      opb_i;
   logic                           busy_o;
   logic                           done_o;
   logic [SW-1:0]                  stage_o;
   logic                           stage_enter_o;
   logic [STEP_W-1:0]              step_o;
   logic [CHANNELS*WIDTH-1:0]      acc_o;

   modport master (
      output start_i, valid_i, boundary_i, mode_i,
      output clear_mask_i, opa_i, opb_i,
      input  busy_o, done_o, stage_o, stage_enter_o,
      input  step_o, acc_o
   );

   modport slave (
      input  start_i, valid_i, boundary_i, mode_i,
      input  clear_mask_i, opa_i, opb_i,
      output busy_o, done_o, stage_o, stage_enter_o,
      output step_o, acc_o
   );
endinterface

// File: rtl/pipe_stage_seq.sv
// Programmable stage/step sequencer driving per-channel FP16 accumulators.
// Arithmetic is FP16 add/mul with round-to-nearest-even, unfused for mac.
module pipe_stage_seq #(
   parameter int CHANNELS   = 3,
   parameter int NUM_STAGES = 8,
   parameter int STEP_W     = 16,
   parameter int WIDTH      = 16
) (
   input logic clk_i,
   input logic rst_i,
   pipe_stage_seq_if.slave bus
);
   localparam int SW = $clog2(NUM_STAGES + 1);

   function automatic logic [15:0] fp16_add(
      input logic [15:0] a,
      input logic [15:0] b
   );
      logic        sa, sb, st, up;
      logic [4:0]  xa, xb, d;
      logic [10:0] ma, mb;
      logic [13:0] al, bl;
      logic [14:0] sum;
      logic [11:0] mr;
      int          e;
      if ((a[14:10] == 5'h1F && a[9:0] != 0) ||
          (b[14:10] == 5'h1F && b[9:0] != 0))
         return 16'h7E00;
      if (a[14:10] == 5'h1F) begin
         if (b[14:10] == 5'h1F && a[15] != b[15])
            return 16'h7E00;
         return a;
      end
      if (b[14:10] == 5'h1F)
         return b;
      sa = a[15];
      sb = b[15];
      xa = (a[14:10] == 0) ? 5'd1 : a[14:10];
      xb = (b[14:10] == 0) ? 5'd1 : b[14:10];
      ma = {a[14:10] != 0, a[9:0]};
      mb = {b[14:10] != 0, b[9:0]};
      if ({xa, ma} < {xb, mb}) begin
         {sa, sb} = {sb, sa};
         {xa, xb} = {xb, xa};
         {ma, mb} = {mb, ma};
      end
      d  = xa - xb;
      al = {ma, 3'b000};
      bl = {mb, 3'b000};
      st = 1'b0;
      for (int i = 0; i < 32; i++) begin
         if (i < int'(d)) begin
            st = st | bl[0];
            bl = bl >> 1;
         end
      end
      bl[0] = bl[0] | st;
      sum = (sa == sb) ? ({1'b0, al} + {1'b0, bl})
                       : ({1'b0, al} - {1'b0, bl});
      if (sum == 0)
         return {sa & sb, 15'h0000};
      e = int'(xa);
      if (sum[14]) begin
         sum = {1'b0, sum[14:2], sum[1] | sum[0]};
         e = e + 1;
      end
      for (int i = 0; i < 14; i++) begin
         if (!sum[13] && e > 1) begin
            sum = sum << 1;
            e = e - 1;
         end
      end
      up = sum[2] & (sum[1] | sum[0] | sum[3]);
      mr = {1'b0, sum[13:3]} + 12'(up);
      if (mr[11]) begin
         mr = mr >> 1;
         e = e + 1;
      end
      if (e >= 31)
         return {sa, 5'h1F, 10'h000};
      return {sa, mr[10] ? 5'(e) : 5'd0, mr[9:0]};
   endfunction

   function automatic logic [15:0] fp16_mul(
      input logic [15:0] a,
      input logic [15:0] b
   );
      logic        sr, st, up;
      logic        an, bn, ai, bi, az, bz;
      logic [10:0] ma, mb;
      logic [21:0] p;
      logic [11:0] mr;
      int          e;
      sr = a[15] ^ b[15];
      an = (a[14:10] == 5'h1F) && (a[9:0] != 0);
      bn = (b[14:10] == 5'h1F) && (b[9:0] != 0);
      ai = (a[14:10] == 5'h1F) && (a[9:0] == 0);
      bi = (b[14:10] == 5'h1F) && (b[9:0] == 0);
      az = (a[14:0] == 0);
      bz = (b[14:0] == 0);
      if (an || bn || (ai && bz) || (bi && az))
         return 16'h7E00;
      if (ai || bi)
         return {sr, 5'h1F, 10'h000};
      if (az || bz)
         return {sr, 15'h0000};
      ma = {a[14:10] != 0, a[9:0]};
      mb = {b[14:10] != 0, b[9:0]};
      p  = 22'(ma) * 22'(mb);
      e  = ((a[14:10] == 0) ? 1 : int'(a[14:10])) +
           ((b[14:10] == 0) ? 1 : int'(b[14:10])) - 15;
      st = 1'b0;
      for (int i = 0; i < 22; i++) begin
         if (!p[21] && !p[20]) begin
            p = p << 1;
            e = e - 1;
         end
      end
      if (p[21]) begin
         st = p[0];
         p = p >> 1;
         e = e + 1;
      end
      // Underflow: denormalise into the subnormal range, keeping sticky
      for (int i = 0; i < 40; i++) begin
         if (e < 1) begin
            st = st | p[0];
            p = p >> 1;
            e = e + 1;
         end
      end
      up = p[9] & ((|p[8:0]) | st | p[10]);
      mr = {1'b0, p[20:10]} + 12'(up);
      if (mr[11]) begin
         mr = mr >> 1;
         e = e + 1;
      end
      if (e >= 31)
         return {sr, 5'h1F, 10'h000};
      return {sr, mr[10] ? 5'(e) : 5'd0, mr[9:0]};
   endfunction

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_e;

   state_e                       state_q, state_d;
   logic [STEP_W-1:0]            step_q, step_d;
   logic [NUM_STAGES*STEP_W-1:0] bnd_q, bnd_d;
   logic [NUM_STAGES*2-1:0]      mode_q, mode_d;
   logic [NUM_STAGES-1:0]        clr_q, clr_d;
   logic [CHANNELS*WIDTH-1:0]    acc_q, acc_d;

   logic [STEP_W-1:0] bnd_a [NUM_STAGES+1];
   logic [STEP_W-1:0] prev_bnd, last_bnd, in_last;
   logic [SW-1:0]     stage;
   logic [1:0]        cur_mode;
   logic              cur_clr, hit, enter, run, adv, accept;

   assign run      = (state_q == S_RUN);
   assign adv      = run && bus.valid_i;
   assign accept   = (state_q == S_IDLE) && bus.start_i;
   assign last_bnd = bnd_a[NUM_STAGES];
   assign in_last  =
      bus.boundary_i[(NUM_STAGES-1)*STEP_W +: STEP_W];

   // bnd_a[s] is the start step of stage s
   always_comb begin
      bnd_a[0] = '0;
      for (int s = 0; s < NUM_STAGES; s++)
         bnd_a[s+1] = bnd_q[s*STEP_W +: STEP_W];
   end

   always_comb begin
      stage    = SW'(NUM_STAGES);
      hit      = 1'b0;
      prev_bnd = '0;
      cur_mode = 2'b00;
      cur_clr  = 1'b0;
      for (int s = NUM_STAGES - 1; s >= 0; s--) begin
         if (step_q < bnd_a[s+1]) begin
            stage    = SW'(s);
            hit      = 1'b1;
            prev_bnd = bnd_a[s];
            cur_mode = mode_q[s*2 +: 2];
            cur_clr  = clr_q[s];
         end
      end
   end

   assign enter = run && hit &&
                  (step_q == '0 || step_q == prev_bnd);

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:
            if (bus.start_i)
               state_d = (in_last != '0) ? S_RUN : S_DONE;
         S_RUN:
            if (bus.valid_i && step_q == last_bnd - STEP_W'(1))
               state_d = S_DONE;
         S_DONE:
            state_d = S_IDLE;
         default:
            state_d = S_IDLE;
      endcase
   end

   always_comb begin
      step_d = step_q;
      bnd_d  = bnd_q;
      mode_d = mode_q;
      clr_d  = clr_q;
      if (accept) begin
         step_d = '0;
         bnd_d  = bus.boundary_i;
         mode_d = bus.mode_i;
         clr_d  = bus.clear_mask_i;
      end else if (adv) begin
         step_d = step_q + STEP_W'(1);
      end
   end

   for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
      logic [WIDTH-1:0] a, b, base, prod, nxt;
      assign a    = bus.opa_i[c*WIDTH +: WIDTH];
      assign b    = bus.opb_i[c*WIDTH +: WIDTH];
      assign base = (enter && cur_clr) ? '0
                                       : acc_q[c*WIDTH +: WIDTH];
      assign prod = fp16_mul(a, b);
      always_comb begin
         unique case (cur_mode)
            2'b00:   nxt = base;
            2'b01:   nxt = fp16_add(base, a);
            2'b10:   nxt = fp16_add(base, prod);
            default: nxt = a;
         endcase
      end
      assign acc_d[c*WIDTH +: WIDTH] =
         adv ? nxt : acc_q[c*WIDTH +: WIDTH];
   end

   always_ff @(posedge clk_i) begin
      if (rst_i)
         state_q <= S_IDLE;
      else
         state_q <= state_d;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         step_q <= '0;
         bnd_q  <= '0;
         mode_q <= '0;
         clr_q  <= '0;
         acc_q  <= '0;
      end else begin
         step_q <= step_d;
         bnd_q  <= bnd_d;
         mode_q <= mode_d;
         clr_q  <= clr_d;
         acc_q  <= acc_d;
      end
   end

   assign bus.busy_o        = run;
   assign bus.done_o        = (state_q == S_DONE);
   assign bus.stage_o       = run ? stage : SW'(NUM_STAGES);
   assign bus.stage_enter_o = enter;
   assign bus.step_o        = step_q;
   assign bus.acc_o         = acc_q;
endmodule

// File: tb/tb_pipe_stage_seq.sv
// Directed checks for pipe_stage_seq: reset, add/load/mac runs,
// stalls, late clears, zero-length runs and ignored starts.
module tb_pipe_stage_seq;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   npass = 0;
   int   nfail = 0;
   int   ntot  = 0;

   always #5 clk = ~clk;

   pipe_stage_seq_if #(
      .CHANNELS(3), .NUM_STAGES(8), .STEP_W(16), .WIDTH(16)
   ) bus ();

   pipe_stage_seq #(
      .CHANNELS(3), .NUM_STAGES(8), .STEP_W(16), .WIDTH(16)
   ) dut (
      .clk_i(clk),
      .rst_i(rst),
      .bus  (bus)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(
      input string       tag,
      input logic [63:0] obs,
      input logic [63:0] exp
   );
      ntot++;
      assert (obs === exp) npass++;
      else begin
         nfail++;
         $error("FAIL %s: observed %0h expected %0h",
                tag, obs, exp);
      end
   endtask

   task automatic cfg(
      input logic [127:0] b,
      input logic [15:0]  m,
      input logic [7:0]   c
   );
      bus.boundary_i   = b;
      bus.mode_i       = m;
      bus.clear_mask_i = c;
   endtask

   initial begin
      bus.start_i = 1'b0;
      bus.valid_i = 1'b0;
      bus.opa_i   = '0;
      bus.opb_i   = '0;
      cfg('0, '0, '0);
      tick;
      tick;
      rst = 1'b0;
      chk("rst_busy", 64'(bus.busy_o), 0);
      chk("rst_done", 64'(bus.done_o), 0);
      chk("rst_stage", 64'(bus.stage_o), 8);
      chk("rst_step", 64'(bus.step_o), 0);
      chk("rst_enter", 64'(bus.stage_enter_o), 0);
      chk("rst_acc", 64'(bus.acc_o), 0);

      // single add stage with clear; config changes mid-run are ignored
      cfg({8{16'd4}}, 16'h0001, 8'h01);
      bus.opa_i   = {3{16'h3C00}};
      bus.start_i = 1'b1;
      tick;
      bus.start_i = 1'b0;
      cfg('0, 16'hFFFF, 8'h00);
      chk("add_busy0", 64'(bus.busy_o), 1);
      chk("add_step0", 64'(bus.step_o), 0);
      chk("add_stage0", 64'(bus.stage_o), 0);
      chk("add_enter0", 64'(bus.stage_enter_o), 1);
      bus.valid_i = 1'b1;
      tick;
      chk("add_acc1", 64'(bus.acc_o), {3{16'h3C00}});
      chk("add_step1", 64'(bus.step_o), 1);
      chk("add_enter1", 64'(bus.stage_enter_o), 0);
      tick;
      chk("add_acc2", 64'(bus.acc_o), {3{16'h4000}});
      tick;
      chk("add_acc3", 64'(bus.acc_o), {3{16'h4200}});
      chk("add_busy3", 64'(bus.busy_o), 1);
      chk("add_done3", 64'(bus.done_o), 0);
      tick;
      chk("add_done", 64'(bus.done_o), 1);
      chk("add_busy_end", 64'(bus.busy_o), 0);
      chk("add_acc_end", 64'(bus.acc_o), {3{16'h4400}});
      chk("add_stage_end", 64'(bus.stage_o), 8);
      bus.valid_i = 1'b0;
      tick;
      chk("add_done_clr", 64'(bus.done_o), 0);

      // load then mac, stages 2..7 empty
      cfg({{7{16'd3}}, 16'd1}, 16'h000B, 8'h00);
      bus.opa_i   = {16'h4400, 16'h3C00, 16'h4000};
      bus.start_i = 1'b1;
      tick;
      bus.start_i = 1'b0;
      chk("lm_stage0", 64'(bus.stage_o), 0);
      chk("lm_enter0", 64'(bus.stage_enter_o), 1);
      bus.valid_i = 1'b1;
      tick;
      chk("lm_acc_load", 64'(bus.acc_o),
          {16'h4400, 16'h3C00, 16'h4000});
      chk("lm_stage1", 64'(bus.stage_o), 1);
      chk("lm_enter1", 64'(bus.stage_enter_o), 1);
      bus.opa_i = {3{16'h3C00}};
      bus.opb_i = {3{16'h4000}};
      tick;
      chk("lm_acc_mac1", 64'(bus.acc_o),
          {16'h4600, 16'h4200, 16'h4400});
      chk("lm_stage2", 64'(bus.stage_o), 1);
      chk("lm_enter2", 64'(bus.stage_enter_o), 0);
      tick;
      chk("lm_done", 64'(bus.done_o), 1);
      chk("lm_acc_mac2", 64'(bus.acc_o),
          {16'h4800, 16'h4500, 16'h4600});
      bus.valid_i = 1'b0;
      tick;

      // stall three cycles after step 1
      cfg({8{16'd4}}, 16'h0001, 8'h01);
      bus.opa_i   = {3{16'h3C00}};
      bus.start_i = 1'b1;
      tick;
      bus.start_i = 1'b0;
      bus.valid_i = 1'b1;
      tick;
      chk("st_acc1", 64'(bus.acc_o), {3{16'h3C00}});
      bus.valid_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick;
         chk("st_hold_step", 64'(bus.step_o), 1);
         chk("st_hold_acc", 64'(bus.acc_o), {3{16'h3C00}});
         chk("st_hold_busy", 64'(bus.busy_o), 1);
      end
      bus.valid_i = 1'b1;
      tick;
      tick;
      chk("st_done_early", 64'(bus.done_o), 0);
      chk("st_step3", 64'(bus.step_o), 3);
      tick;
      chk("st_done", 64'(bus.done_o), 1);
      chk("st_acc_end", 64'(bus.acc_o), {3{16'h4400}});
      bus.valid_i = 1'b0;
      tick;

      // zero-length run
      cfg('0, '0, '0);
      bus.start_i = 1'b1;
      tick;
      bus.start_i = 1'b0;
      chk("z_done", 64'(bus.done_o), 1);
      chk("z_busy", 64'(bus.busy_o), 0);
      chk("z_acc", 64'(bus.acc_o), {3{16'h4400}});
      tick;
      chk("z_done_clr", 64'(bus.done_o), 0);
      chk("z_busy_after", 64'(bus.busy_o), 0);

      // hold with clear; a start mid-run must be ignored
      cfg({8{16'd4}}, 16'h0000, 8'h01);
      bus.start_i = 1'b1;
      tick;
      bus.start_i = 1'b0;
      bus.valid_i = 1'b1;
      tick;
      chk("sb_acc_clr", 64'(bus.acc_o), 0);
      bus.start_i = 1'b1;
      cfg('0, '0, '0);
      tick;
      bus.start_i = 1'b0;
      chk("sb_busy2", 64'(bus.busy_o), 1);
      chk("sb_step2", 64'(bus.step_o), 2);
      tick;
      chk("sb_done3", 64'(bus.done_o), 0);
      tick;
      chk("sb_done", 64'(bus.done_o), 1);
      chk("sb_acc", 64'(bus.acc_o), 0);
      bus.valid_i = 1'b0;
      tick;
      chk("sb_idle", 64'(bus.busy_o), 0);

      // reset in the middle of a run
      cfg({8{16'd4}}, 16'h0001, 8'h01);
      bus.opa_i   = {3{16'h3C00}};
      bus.start_i = 1'b1;
      tick;
      bus.start_i = 1'b0;
      bus.valid_i = 1'b1;
      tick;
      tick;
      chk("mr_acc_pre", 64'(bus.acc_o), {3{16'h4000}});
      rst = 1'b1;
      tick;
      rst = 1'b0;
      bus.valid_i = 1'b0;
      chk("mr_busy", 64'(bus.busy_o), 0);
      chk("mr_done", 64'(bus.done_o), 0);
      chk("mr_stage", 64'(bus.stage_o), 8);
      chk("mr_acc", 64'(bus.acc_o), 0);
      chk("mr_step", 64'(bus.step_o), 0);
      tick;
      chk("mr_done_after", 64'(bus.done_o), 0);

      // clear only on the second stage
      cfg({{6{16'd4}}, 16'd4, 16'd2}, 16'h0005, 8'h02);
      bus.opa_i   = {3{16'h4000}};
      bus.start_i = 1'b1;
      tick;
      bus.start_i = 1'b0;
      chk("lc_enter0", 64'(bus.stage_enter_o), 1);
      bus.valid_i = 1'b1;
      tick;
      chk("lc_acc1", 64'(bus.acc_o), {3{16'h4000}});
      tick;
      chk("lc_acc_s0", 64'(bus.acc_o), {3{16'h4400}});
      chk("lc_stage1", 64'(bus.stage_o), 1);
      chk("lc_enter1", 64'(bus.stage_enter_o), 1);
      tick;
      chk("lc_acc3", 64'(bus.acc_o), {3{16'h4000}});
      tick;
      chk("lc_done", 64'(bus.done_o), 1);
      chk("lc_acc_end", 64'(bus.acc_o), {3{16'h4400}});
      bus.valid_i = 1'b0;
      tick;

      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end
endmodule
